// File: rtl/mult_accumulator.sv
// ============================================================================
// Module: mult_accumulator
//
// Purpose
//   Accumulate stage that sits after the 4-bit signed multiplier. It takes
//   signed product words over a valid/ready handshake and adds up TERMS of
//   them in a row. It then presents the signed total and an overflow flag,
//   and holds both until the consumer takes them. This is the accumulate
//   half of the ALU multiply-accumulate path.
//
// Parameters
//   P_W    width of the incoming signed product word
//   ACC_W  width of the signed accumulator and the sum output (ACC_W >= P_W)
//   TERMS  number of products summed per result (TERMS >= 1)
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous active-high reset
//   clear      in   1      synchronous abort; drops any partial or held result
//   in_valid   in   1      prod is valid this cycle
//   in_ready   out  1      block accepts prod this cycle (set while collecting)
//   prod       in   P_W    signed product word
//   out_valid  out  1      sum/ovf hold a finished result
//   out_ready  in   1      consumer takes the result this cycle
//   sum        out  ACC_W  signed accumulated result
//   ovf        out  1      sticky; the true running sum left the ACC_W range
//
// Build option
//   MULT_ACC_SATURATE_EN  when defined, an overflowing add clamps the
//                         accumulator to the most positive or most negative
//                         ACC_W value. When undefined, the accumulator wraps
//                         modulo 2^ACC_W. ovf behaves the same in both builds.
// ============================================================================
module mult_accumulator #(
    parameter int P_W   = 4,
    parameter int ACC_W = 8,
    parameter int TERMS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [P_W-1:0]   prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    // The term counter needs at least one bit, even when TERMS == 1.
    localparam int CNT_W = (TERMS > 1) ? $clog2(TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TERMS - 1);

    // Clamp limits for the saturating build.
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   sum_q,   sum_d;
    logic               ovf_q,   ovf_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [ACC_W:0]     add_ext;
    logic               add_ovf;
    logic [ACC_W-1:0]   add_result;

    // The add uses one guard bit. The accumulator and the product are both
    // already within the ACC_W signed range, so ACC_W+1 bits always hold the
    // exact result. Overflow shows as a mismatch between the top two bits.
    always_comb begin
        add_ext = {sum_q[ACC_W-1], sum_q}
                + {{(ACC_W + 1 - P_W){prod[P_W-1]}}, prod};
        add_ovf = add_ext[ACC_W] ^ add_ext[ACC_W-1];
`ifdef MULT_ACC_SATURATE_EN
        // The guard bit holds the true sign, so it picks the clamp direction.
        if (add_ovf) begin
            add_result = add_ext[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            add_result = add_ext[ACC_W-1:0];
        end
`else
        add_result = add_ext[ACC_W-1:0];
`endif
    end

    // Next-state logic. clear returns the block to its reset values and wins
    // over any handshake in the same cycle. In HOLD the input side is
    // ignored. A release only empties the accumulator, so the earliest a new
    // product can be accepted is the cycle after the release.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        count_d = count_q;

        if (clear) begin
            state_d = COLLECT;
            sum_d   = '0;
            ovf_d   = 1'b0;
            count_d = '0;
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (in_valid) begin
                        sum_d = add_result;
                        ovf_d = ovf_q | add_ovf;
                        if (count_q == LAST_CNT) begin
                            state_d = HOLD;
                            count_d = '0;
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = COLLECT;
                        sum_d   = '0;
                        ovf_d   = 1'b0;
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = COLLECT;
                end
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COLLECT;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

    // The handshake outputs are decoded only from the registered state.
    // Because of this, there is no combinational path from out_ready to
    // in_ready.
    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == HOLD);
    assign sum       = sum_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// ============================================================================
// Testbench: tb_mult_accumulator
//
// Three accumulators are driven side by side:
//   index 0 : P_W=4, ACC_W=8, TERMS=4 (the reference configuration)
//   index 1 : P_W=4, ACC_W=5, TERMS=4 (narrow, so overflow is easy to reach)
//   index 2 : P_W=4, ACC_W=8, TERMS=1 (every accept finishes a result)
// The reference model keeps, for each instance, the list of products
// accepted toward the current result. The expected sum and ovf are folded
// from that list with plain integer arithmetic.
// ============================================================================
module tb_mult_accumulator;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] clear_v, in_valid_v, out_ready_v;
    logic [2:0] in_ready_v, out_valid_v, ovf_v;
    logic [3:0] prod_v [3];
    logic [7:0] sum_a;
    logic [4:0] sum_b;
    logic [7:0] sum_c;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mult_accumulator #(.P_W(4), .ACC_W(8), .TERMS(4)) u_dut_a (
        .clk(clk), .reset(reset), .clear(clear_v[0]),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .prod(prod_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .sum(sum_a), .ovf(ovf_v[0])
    );

    mult_accumulator #(.P_W(4), .ACC_W(5), .TERMS(4)) u_dut_b (
        .clk(clk), .reset(reset), .clear(clear_v[1]),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .prod(prod_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .sum(sum_b), .ovf(ovf_v[1])
    );

    mult_accumulator #(.P_W(4), .ACC_W(8), .TERMS(1)) u_dut_c (
        .clk(clk), .reset(reset), .clear(clear_v[2]),
        .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]), .prod(prod_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .sum(sum_c), .ovf(ovf_v[2])
    );

    // Reference model: products accepted toward the current result, plus a
    // flag that says the result is complete and waiting for the consumer.
    localparam int ACC_WS [3] = '{8, 5, 8};
    localparam int TERMS_S [3] = '{4, 4, 1};
`ifdef MULT_ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    int terms_m [3][8];
    int n_m [3];
    bit full_m [3];

    // Fold the accepted products into the expected sum and overflow flag.
    function automatic void fold(input int k, output int acc, output bit ov);
        int lo, hi, m;
        lo = -(1 << (ACC_WS[k] - 1));
        hi = (1 << (ACC_WS[k] - 1)) - 1;
        m  = 1 << ACC_WS[k];
        acc = 0;
        ov  = 1'b0;
        for (int i = 0; i < n_m[k]; i++) begin
            acc = acc + terms_m[k][i];
            if (acc < lo || acc > hi) begin
                ov = 1'b1;
                if (SAT) begin
                    acc = (acc < lo) ? lo : hi;
                end else begin
                    acc = acc & (m - 1);
                    if (acc > hi) acc = acc - m;
                end
            end
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock. The model is updated from the inputs seen at the
    // edge. The bench then moves 1 time unit past the edge, so outputs are
    // read and new inputs are applied away from the active edge.
    task automatic applyStimulus();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (reset || clear_v[k]) begin
                n_m[k] = 0;
                full_m[k] = 1'b0;
            end else if (full_m[k]) begin
                if (out_ready_v[k]) begin
                    n_m[k] = 0;
                    full_m[k] = 1'b0;
                end
            end else if (in_valid_v[k]) begin
                terms_m[k][n_m[k]] = int'($signed(prod_v[k]));
                n_m[k]++;
                if (n_m[k] == TERMS_S[k]) full_m[k] = 1'b1;
            end
        end
        #1;
    endtask

    function automatic int dut_sum(input int k);
        case (k)
            0: return int'($signed(sum_a));
            1: return int'($signed(sum_b));
            default: return int'($signed(sum_c));
        endcase
    endfunction

    // Compare one instance against the reference model.
    task automatic checkOutput(input int k, input string tag);
        int acc;
        bit ov;
        fold(k, acc, ov);
        check($sformatf("%s[%0d].in_ready", tag, k), int'(in_ready_v[k]), int'(!full_m[k]));
        check($sformatf("%s[%0d].out_valid", tag, k), int'(out_valid_v[k]), int'(full_m[k]));
        check($sformatf("%s[%0d].sum", tag, k), dut_sum(k), acc);
        check($sformatf("%s[%0d].ovf", tag, k), int'(ovf_v[k]), int'(ov));
    endtask

    task automatic idleAll();
        clear_v = '0;
        in_valid_v = '0;
        out_ready_v = '0;
        for (int k = 0; k < 3; k++) prod_v[k] = 4'h0;
    endtask

    typedef struct {
        logic       iv;
        logic [3:0] p;
        logic       ordy;
        logic       clr;
        logic       eov;
        logic       eir;
        logic [7:0] esum;
        logic       eovf;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [3:0] p, input logic ordy,
                                input logic clr, input logic eov, input logic eir,
                                input logic [7:0] esum, input logic eovf);
        vec_t v;
        v.iv = iv; v.p = p; v.ordy = ordy; v.clr = clr;
        v.eov = eov; v.eir = eir; v.esum = esum; v.eovf = eovf;
        return v;
    endfunction

    initial begin
        vec_t vecs[$];
        logic [4:0] exp_b;

        for (int k = 0; k < 3; k++) begin
            n_m[k] = 0;
            full_m[k] = 1'b0;
        end

        // Vectors for instance 0. Expected values are the outputs just after
        // the edge on which the inputs were presented.
        // Basic 4-term sum: 0 + -2 + -1 + 0 = -3.
        vecs.push_back(mk(1, 4'h0, 0, 0, 0, 1, 8'h00, 0));
        vecs.push_back(mk(1, 4'hE, 0, 0, 0, 1, 8'hFE, 0));
        vecs.push_back(mk(1, 4'hF, 0, 0, 0, 1, 8'hFD, 0));
        vecs.push_back(mk(1, 4'h0, 0, 0, 1, 0, 8'hFD, 0));
        // Backpressure: the held result is stable and new input is ignored.
        vecs.push_back(mk(1, 4'h7, 0, 0, 1, 0, 8'hFD, 0));
        vecs.push_back(mk(1, 4'h7, 0, 0, 1, 0, 8'hFD, 0));
        vecs.push_back(mk(1, 4'h7, 0, 0, 1, 0, 8'hFD, 0));
        // Release: nothing is accepted in the release cycle.
        vecs.push_back(mk(1, 4'h7, 1, 0, 0, 1, 8'h00, 0));
        // Gaps in in_valid: 4 x -4, completed only on the fourth accept.
        vecs.push_back(mk(1, 4'hC, 0, 0, 0, 1, 8'hFC, 0));
        vecs.push_back(mk(0, 4'hC, 0, 0, 0, 1, 8'hFC, 0));
        vecs.push_back(mk(1, 4'hC, 0, 0, 0, 1, 8'hF8, 0));
        vecs.push_back(mk(0, 4'hC, 0, 0, 0, 1, 8'hF8, 0));
        vecs.push_back(mk(1, 4'hC, 0, 0, 0, 1, 8'hF4, 0));
        vecs.push_back(mk(1, 4'hC, 0, 0, 1, 0, 8'hF0, 0));
        vecs.push_back(mk(0, 4'h0, 1, 0, 0, 1, 8'h00, 0));
        // clear after two accepts, then four ones.
        vecs.push_back(mk(1, 4'h7, 0, 0, 0, 1, 8'h07, 0));
        vecs.push_back(mk(1, 4'h7, 0, 0, 0, 1, 8'h0E, 0));
        vecs.push_back(mk(1, 4'h7, 0, 1, 0, 1, 8'h00, 0));
        vecs.push_back(mk(1, 4'h1, 0, 0, 0, 1, 8'h01, 0));
        vecs.push_back(mk(1, 4'h1, 0, 0, 0, 1, 8'h02, 0));
        vecs.push_back(mk(1, 4'h1, 0, 0, 0, 1, 8'h03, 0));
        vecs.push_back(mk(1, 4'h1, 0, 0, 1, 0, 8'h04, 0));
        // clear during HOLD drops the result.
        vecs.push_back(mk(0, 4'h0, 0, 1, 0, 1, 8'h00, 0));

        // Reset.
        idleAll();
        reset = 1'b1;
        applyStimulus();
        applyStimulus();
        reset = 1'b0;
        check("reset.sum", int'(sum_a), 0);
        check("reset.in_ready", int'(in_ready_v[0]), 1);
        check("reset.out_valid", int'(out_valid_v[0]), 0);
        check("reset.ovf", int'(ovf_v[0]), 0);
        for (int k = 0; k < 3; k++) checkOutput(k, "reset");

        // Table-driven directed vectors on instance 0.
        foreach (vecs[i]) begin
            in_valid_v[0]  = vecs[i].iv;
            prod_v[0]      = vecs[i].p;
            out_ready_v[0] = vecs[i].ordy;
            clear_v[0]     = vecs[i].clr;
            applyStimulus();
            check($sformatf("vec%0d.out_valid", i), int'(out_valid_v[0]), int'(vecs[i].eov));
            check($sformatf("vec%0d.in_ready", i), int'(in_ready_v[0]), int'(vecs[i].eir));
            check($sformatf("vec%0d.sum", i), int'(sum_a), int'(vecs[i].esum));
            check($sformatf("vec%0d.ovf", i), int'(ovf_v[0]), int'(vecs[i].eovf));
        end
        idleAll();

        // Overflow on the 5-bit instance: 7 x 4, true total 28.
        exp_b = SAT ? 5'b01111 : 5'b11100;
        in_valid_v[1] = 1'b1;
        prod_v[1] = 4'h7;
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            if (i == 2) begin
                check("ovf5.sticky_before_hold", int'(ovf_v[1]), 1);
                check("ovf5.no_early_valid", int'(out_valid_v[1]), 0);
            end
        end
        in_valid_v[1] = 1'b0;
        check("ovf5.out_valid", int'(out_valid_v[1]), 1);
        check("ovf5.sum", int'(sum_b), int'(exp_b));
        check("ovf5.ovf", int'(ovf_v[1]), 1);
        out_ready_v[1] = 1'b1;
        applyStimulus();
        out_ready_v[1] = 1'b0;
        check("ovf5.release_ovf", int'(ovf_v[1]), 0);
        check("ovf5.release_sum", int'(sum_b), 0);
        checkOutput(1, "ovf5");

        // Reset while a result is held.
        in_valid_v[0] = 1'b1;
        prod_v[0] = 4'h1;
        for (int i = 0; i < 4; i++) applyStimulus();
        in_valid_v[0] = 1'b0;
        check("rsthold.out_valid_before", int'(out_valid_v[0]), 1);
        check("rsthold.sum_before", int'(sum_a), 4);
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        check("rsthold.out_valid", int'(out_valid_v[0]), 0);
        check("rsthold.sum", int'(sum_a), 0);
        check("rsthold.in_ready", int'(in_ready_v[0]), 1);

        // Randomized traffic on all three instances against the model.
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int k = 0; k < 3; k++) begin
                in_valid_v[k]  = ($urandom_range(0, 3) != 0);
                prod_v[k]      = 4'($urandom);
                out_ready_v[k] = ($urandom_range(0, 2) == 0);
                clear_v[k]     = ($urandom_range(0, 39) == 0);
            end
            reset = ($urandom_range(0, 249) == 0);
            applyStimulus();
            for (int k = 0; k < 3; k++) checkOutput(k, $sformatf("rnd%0d", cyc));
        end
        reset = 1'b0;
        idleAll();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
